// File: rtl/quad_decoder.sv
// quad_decoder: synchronised, deglitched quadrature decoder producing step/direction pulses with illegal-transition tracking
module quad_decoder #(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4,
  parameter int ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_in,
  input  logic             b_in,
  input  logic             dec_en,
  input  logic             err_clr,
  output logic             en,
  output logic             up,
  output logic             err,
  output logic             err_flag,
  output logic [ERR_W-1:0] err_cnt
);
  localparam int FW = $clog2(FILTER_CYCLES + 1);
  localparam int IW = $clog2(SYNC_STAGES + FILTER_CYCLES + 1);
  typedef enum logic {INIT, TRACK} state_t;
  state_t                 state_q;
  logic [SYNC_STAGES-1:0] a_sync_q, b_sync_q;
  logic [1:0]             synced, filt_q, filt_d, prev_q, diff;
  logic [1:0][FW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]          init_cnt_q;
  logic                   track, step, illegal, fwd;
  assign synced  = {a_sync_q[SYNC_STAGES-1], b_sync_q[SYNC_STAGES-1]};
  assign diff    = filt_q ^ prev_q;
  assign step    = ^diff;
  assign illegal = &diff;
  // A leads B exactly when the old B differs from the new A
  assign fwd     = prev_q[0] ^ filt_q[1];
  assign track   = (state_q == TRACK) && dec_en;
  always_comb begin
    filt_d = filt_q;
    cnt_d  = cnt_q;
    for (int c = 0; c < 2; c++) begin
      filt_d[c] = (synced[c] != filt_q[c] && cnt_q[c] == FW'(FILTER_CYCLES - 1)) ? synced[c] : filt_q[c];
      cnt_d[c]  = (synced[c] == filt_q[c] || filt_d[c] != filt_q[c]) ? '0 : cnt_q[c] + FW'(1);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= INIT;
      a_sync_q   <= '0;
      b_sync_q   <= '0;
      filt_q     <= '0;
      prev_q     <= '0;
      cnt_q      <= '0;
      init_cnt_q <= '0;
      en         <= 1'b0;
      up         <= 1'b0;
      err        <= 1'b0;
      err_flag   <= 1'b0;
      err_cnt    <= '0;
    end else begin
      a_sync_q <= {a_sync_q[SYNC_STAGES-2:0], a_in};
      b_sync_q <= {b_sync_q[SYNC_STAGES-2:0], b_in};
      en       <= track && step;
      err      <= track && illegal;
      if (track && step) up <= fwd;
      err_cnt  <= err_clr ? '0 : (track && illegal && !(&err_cnt)) ? err_cnt + ERR_W'(1) : err_cnt;
      err_flag <= err_clr ? 1'b0 : err_flag | (track && illegal);
      if (state_q == INIT) begin
        filt_q     <= synced;
        prev_q     <= synced;
        cnt_q      <= '0;
        init_cnt_q <= init_cnt_q + IW'(1);
        if (init_cnt_q == IW'(SYNC_STAGES + FILTER_CYCLES - 1)) state_q <= TRACK;
      end else begin
        filt_q <= filt_d;
        prev_q <= filt_q;
        cnt_q  <= cnt_d;
      end
    end
  end
endmodule

// File: tb/tb_quad_decoder.sv
// tb_quad_decoder: scoreboard bench; each input change queues the pulse expected 7 cycles later
module tb_quad_decoder;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       a_in = 1'b0, b_in = 1'b0, dec_en = 1'b1, err_clr = 1'b0;
  logic       en, up, err, err_flag;
  logic [7:0] err_cnt;
  int         cyc = 0;
  int         n_cmp = 0, n_bad = 0;
  logic [34:0] sb_q[$];
  quad_decoder dut (
    .clk(clk), .rst(rst), .a_in(a_in), .b_in(b_in), .dec_en(dec_en), .err_clr(err_clr),
    .en(en), .up(up), .err(err), .err_flag(err_flag), .err_cnt(err_cnt)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic drive(input logic [1:0] ab, input logic [2:0] ev, input int hold);
    a_in = ab[1];
    b_in = ab[0];
    if (ev != 3'b000) sb_q.push_back({32'(cyc + 7), ev});
    tick(hold);
  endtask
  always @(negedge clk) begin
    if (!rst && (en || err)) begin
      if (sb_q.size() == 0) check("spurious", 64'({32'(cyc), en, up, err}), 64'({32'(cyc), 3'b000}));
      else check("event", 64'({32'(cyc), en, up, err}), 64'(sb_q.pop_front()));
    end
  end
  initial begin
    tick(3);
    check("rst_en", 64'(en), 64'(0));
    check("rst_up", 64'(up), 64'(0));
    check("rst_err", 64'(err), 64'(0));
    check("rst_flag", 64'(err_flag), 64'(0));
    check("rst_cnt", 64'(err_cnt), 64'(0));
    rst = 1'b0;
    tick(10);
    drive(2'b10, 3'b110, 20);
    drive(2'b11, 3'b110, 20);
    drive(2'b01, 3'b110, 20);
    drive(2'b00, 3'b110, 20);
    drive(2'b01, 3'b100, 20);
    drive(2'b11, 3'b100, 20);
    drive(2'b10, 3'b100, 20);
    drive(2'b00, 3'b100, 20);
    check("up_hold", 64'(up), 64'(0));
    drive(2'b10, 3'b000, 3);
    drive(2'b00, 3'b000, 20);
    drive(2'b10, 3'b110, 4);
    drive(2'b00, 3'b100, 20);
    for (int i = 0; i < 300; i++) drive((i % 2 == 0) ? 2'b11 : 2'b00, 3'b001, 8);
    tick(10);
    check("sat_cnt", 64'(err_cnt), 64'(255));
    check("sat_flag", 64'(err_flag), 64'(1));
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    check("clr_cnt", 64'(err_cnt), 64'(0));
    check("clr_flag", 64'(err_flag), 64'(0));
    drive(2'b11, 3'b001, 10);
    check("post_cnt", 64'(err_cnt), 64'(1));
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(30);
    check("rst11_cnt", 64'(err_cnt), 64'(0));
    check("rst11_flag", 64'(err_flag), 64'(0));
    drive(2'b01, 3'b110, 20);
    dec_en = 1'b0;
    drive(2'b00, 3'b000, 20);
    drive(2'b10, 3'b000, 20);
    drive(2'b11, 3'b000, 20);
    drive(2'b01, 3'b000, 20);
    dec_en = 1'b1;
    tick(5);
    drive(2'b11, 3'b100, 20);
    check("gate_up", 64'(up), 64'(0));
    check("gate_flag", 64'(err_flag), 64'(0));
    check("leftover", 64'(sb_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
